race_tx_scheduler: RTL and testbench
====================================

Name: race_tx_scheduler

Overview:
- Sequences the Ethernet transmit path: decides when a player-state packet goes out, freezes a snapshot of player state, and drives the valid/ready/done handshake into the transmit block.
- Sends periodically, and immediately on urgent events (game status change, race reset). Repeats reset packets so the opponent reliably sees them.
- Sits in the eth_refclk domain between game logic and transmit. Payload layout matches the 44-bit word the receive path decodes.

Parameters:
- PERIOD, 500000, eth_refclk cycles between periodic sends (10 ms at 50 MHz); minimum 16.
- TIMEOUT, 4096, cycles allowed from acceptance to tx_done before the packet is abandoned.
- RESET_REPEAT, 3, number of consecutive packets carrying the reset flag after a reset request.

Ports:
- clk_in  input  1  eth_refclk.
- rst_in  input  1  reset; asynchronous, active-low.
- player_x  input  11  player x position.
- player_y  input  11  player y position.
- direction  input  9  heading in degrees, 0-359.
- game_stat  input  3  game status code.
- reset_req  input  1  one-cycle pulse requesting a race reset broadcast.
- tx_ready  input  1  transmit can accept a packet.
- tx_done  input  1  one-cycle pulse when transmit finishes the frame.
- tx_valid  output  1  packet offered to transmit.
- tx_data  output  44  packet payload.
- busy  output  1  high in any state other than IDLE.
- sent_count  output  16  packets completed; wraps.
- timeout_count  output  8  packets abandoned; saturates at 255.

Behaviour:
- Payload bit layout:
  - [43:33] x; [32] 0
  - [31:21] y; [20] 0
  - [19:11] dir; [10:8] 0
  - [7:5] game; [4] 0
  - [3] reset flag
  - [2:0] 3-bit sequence number, incremented per accepted packet, wraps 7->0.
- Reset (rst_in low, asynchronous):
  - State IDLE; tx_valid 0; tx_data 0; busy 0; both counters 0.
  - Period counter 0; sequence 0; reset-repeat count 0; last game_stat register 0.
  - Asserting rst_in mid-handshake drops tx_valid immediately; no packet is counted.
- Period counter:
  - Free-running 0..PERIOD-1; tick on the cycle it wraps to 0.
  - A tick arriving outside IDLE is held pending (single bit, not queued). Multiple ticks collapse into one pending send.
- Urgent events:
  - reset_req loads reset-repeat count with RESET_REPEAT.
  - game_stat differing from the last sent value sets urgent pending.
  - Either event in IDLE starts a send on the next cycle without waiting for the tick.
  - An event arriving while busy sets pending.
- States:
  - IDLE: if any pending, go to SNAP. Consumes both tick-pending and urgent-pending.
  - SNAP (1 cycle):
    - Capture player_x, player_y, direction, game_stat and the sequence number into tx_data.
    - Reset flag = (reset-repeat count != 0).
    - Go to REQ.
  - REQ:
    - tx_valid=1; tx_data held stable.
    - On tx_valid && tx_ready: drop tx_valid next cycle, increment sequence, decrement reset-repeat count if nonzero, record game_stat as last sent, clear timeout counter, go to WAIT.
    - No timeout in REQ; it waits indefinitely for ready.
  - WAIT:
    - On tx_done: sent_count+1, go to HOLD.
    - If the timeout counter reaches TIMEOUT-1 without tx_done: timeout_count+1 (saturating), go to HOLD.
    - tx_done and timeout on the same cycle count as done.
  - HOLD (2 cycles, gap for transmit IFG): go to IDLE.
- Latency: pending set -> tx_valid high is exactly 2 cycles (IDLE->SNAP->REQ).
- While reset-repeat count is nonzero after a completed packet, urgent pending is re-set. The reset packets therefore go back-to-back: RESET_REPEAT packets each carry flag=1, and the next packet carries flag=0.
- reset_req arriving during a reset burst reloads the count to RESET_REPEAT.
- tx_done seen outside WAIT is ignored.

Test Plan:
- Reset, then no events with PERIOD=16 -> tx_valid first rises on cycle 18 after deassert (tick at cycle 16, +2); tx_data seq=0, flag=0, fields equal the inputs at the SNAP cycle.
- tx_ready held low 50 cycles, inputs changing -> tx_valid stays 1 and tx_data stays constant; on ready, sequence advances to 1.
- reset_req pulse in IDLE with tx_ready=1 and done 5 cycles after accept -> 3 consecutive packets with bit3=1 and seq n, n+1, n+2; 4th packet bit3=0; sent_count +3.
- TIMEOUT=32, tx_done never pulsed -> timeout_count=1 and sent_count unchanged after 32 WAIT cycles; return to IDLE after 2 HOLD cycles. After 300 such timeouts -> timeout_count=255.
- game_stat changes 1->2 while in WAIT -> exactly one extra packet immediately after HOLD, with game=2. Two periodic ticks during a 40-cycle ready stall -> only one follow-up send.
- rst_in low while tx_valid=1 -> tx_valid 0 in the same cycle (async); counters 0; the next packet starts at seq 0.

Source files
------------

// File: rtl/race_tx_scheduler.sv
// rtl/race_tx_scheduler.sv - schedules player-state packets into the Ethernet transmit block
// Periodic and urgent sends, snapshot of player state, valid/ready/done handshake with timeout.
module race_tx_scheduler #(
  parameter int PERIOD       = 500000,
  parameter int TIMEOUT      = 4096,
  parameter int RESET_REPEAT = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] player_x,
  input  logic [10:0] player_y,
  input  logic [8:0]  direction,
  input  logic [2:0]  game_stat,
  input  logic        reset_req,
  input  logic        tx_ready,
  input  logic        tx_done,
  output logic        tx_valid,
  output logic [43:0] tx_data,
  output logic        busy,
  output logic [15:0] sent_count,
  output logic [7:0]  timeout_count
);

  localparam int PW = $clog2(PERIOD);
  localparam int TW = $clog2(TIMEOUT);
  localparam int RW = $clog2(RESET_REPEAT + 1);
  localparam logic [PW-1:0] P_LAST = PW'(PERIOD - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [RW-1:0] R_LOAD = RW'(RESET_REPEAT);

  typedef enum logic [2:0] {IDLE, SNAP, REQ, WAIT, HOLD} state_t;

  state_t        state;
  logic [PW-1:0] period_cnt;
  logic [TW-1:0] to_cnt;
  logic [RW-1:0] rst_cnt;
  logic [2:0]    seq;
  logic [2:0]    last_stat;
  logic          tick_pend;
  logic          urg_pend;
  logic          hold_cnt;

  logic       tick;
  logic       go;
  logic       accept;
  logic       wait_end;
  logic [2:0] stat_ref;
  logic       stat_event;

  assign tick     = (period_cnt == P_LAST);
  assign go       = (state == IDLE) && (tick_pend || urg_pend);
  assign accept   = (state == REQ) && tx_valid && tx_ready;
  assign wait_end = (state == WAIT) && (tx_done || to_cnt == T_LAST);
  // While offering, compare against the snapshot so the packet in flight doesn't retrigger itself.
  assign stat_ref   = (state == REQ) ? tx_data[7:5] : last_stat;
  assign stat_event = (state != SNAP) && (game_stat != stat_ref);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state         <= IDLE;
      period_cnt    <= '0;
      to_cnt        <= '0;
      rst_cnt       <= '0;
      seq           <= '0;
      last_stat     <= '0;
      tick_pend     <= 1'b0;
      urg_pend      <= 1'b0;
      hold_cnt      <= 1'b0;
      tx_valid      <= 1'b0;
      tx_data       <= '0;
      busy          <= 1'b0;
      sent_count    <= '0;
      timeout_count <= '0;
    end else begin
      period_cnt <= tick ? '0 : period_cnt + 1'b1;
      tick_pend  <= go ? 1'b0 : (tick_pend | tick);

      // Leaving IDLE consumes every pending reason; the snapshot covers them all.
      if (go)
        urg_pend <= 1'b0;
      else if (reset_req || stat_event || (wait_end && rst_cnt != '0))
        urg_pend <= 1'b1;

      if (reset_req)
        rst_cnt <= R_LOAD;
      else if (accept && rst_cnt != '0)
        rst_cnt <= rst_cnt - 1'b1;

      case (state)
        IDLE: begin
          if (go) begin
            state <= SNAP;
            busy  <= 1'b1;
          end
        end
        SNAP: begin
          tx_data  <= {player_x, 1'b0, player_y, 1'b0, direction, 3'b000,
                       game_stat, 1'b0, (rst_cnt != '0), seq};
          tx_valid <= 1'b1;
          state    <= REQ;
        end
        REQ: begin
          if (accept) begin
            tx_valid  <= 1'b0;
            seq       <= seq + 1'b1;
            last_stat <= tx_data[7:5];
            to_cnt    <= '0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (tx_done) begin
            sent_count <= sent_count + 1'b1;
            hold_cnt   <= 1'b0;
            state      <= HOLD;
          end else if (to_cnt == T_LAST) begin
            if (timeout_count != 8'hff)
              timeout_count <= timeout_count + 1'b1;
            hold_cnt <= 1'b0;
            state    <= HOLD;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (hold_cnt) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            hold_cnt <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_race_tx_scheduler.sv
// tb/tb_race_tx_scheduler.sv - directed scoreboard bench for race_tx_scheduler
// Edge numbers count rising edges since reset release; outputs sampled 1 time unit after each edge.
module tb_race_tx_scheduler;

  localparam int PER  = 16;
  localparam int NONE = 1 << 30;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [10:0] player_x;
  logic [10:0] player_y;
  logic [8:0]  direction;
  logic [2:0]  game_stat;
  logic        reset_req;
  logic        tx_ready;
  logic        tx_done;
  logic        tx_valid;
  logic [43:0] tx_data;
  logic        busy;
  logic [15:0] sent_count;
  logic [7:0]  timeout_count;

  race_tx_scheduler #(.PERIOD(PER), .TIMEOUT(32), .RESET_REPEAT(3)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .player_x(player_x), .player_y(player_y),
    .direction(direction), .game_stat(game_stat), .reset_req(reset_req),
    .tx_ready(tx_ready), .tx_done(tx_done), .tx_valid(tx_valid), .tx_data(tx_data),
    .busy(busy), .sent_count(sent_count), .timeout_count(timeout_count)
  );

  always #5 clk_in = ~clk_in;

  int cyc;
  always @(posedge clk_in or negedge rst_in)
    if (!rst_in) cyc <= 0;
    else cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [43:0] exp_q[$];
  logic [2:0]  m_seq;
  int m_rcnt, m_sent, v_edge, i_edge, last_c;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  function automatic int next_tick(input int c);
    return (c / PER + 1) * PER;
  endfunction

  // Edge at which tx_valid rises: pending is set at min(tick, urgent event), acted on once back in IDLE.
  function automatic int pred(input int i, input int c, input int e);
    int t, m;
    t = next_tick(c);
    m = (t < e) ? t : e;
    return ((m > i) ? m : i) + 2;
  endfunction

  task automatic push_exp();
    exp_q.push_back({player_x, 1'b0, player_y, 1'b0, direction, 3'b000,
                     game_stat, 1'b0, (m_rcnt != 0), m_seq});
  endtask

  task automatic await_pkt(input string tag, input int exp_edge);
    int n = 0;
    while (!tx_valid && n < 200) begin
      step(1);
      n++;
    end
    check({tag, "_valid"}, tx_valid, 1);
    check({tag, "_edge"}, cyc, exp_edge);
    v_edge = cyc;
  endtask

  task automatic accept(input string tag);
    logic [43:0] e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    check({tag, "_data"}, tx_data, e);
    tx_ready = 1'b1;
    step(1);
    tx_ready = 1'b0;
    m_seq++;
    if (m_rcnt > 0) m_rcnt--;
    check({tag, "_drop"}, tx_valid, 0);
  endtask

  task automatic run_pkt(input string tag, input int dly);
    accept(tag);
    step(dly);
    tx_done = 1'b1;
    step(1);
    tx_done = 1'b0;
    m_sent++;
    i_edge = cyc + 2;
    last_c = v_edge - 1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    player_x = 11'h123; player_y = 11'h456; direction = 9'd200; game_stat = 3'd0;
    reset_req = 1'b0; tx_ready = 1'b0; tx_done = 1'b0;
    m_seq = 3'd0; m_rcnt = 0; m_sent = 0; i_edge = 0; last_c = 0;

    step(2);
    check("rst_valid", tx_valid, 0);
    check("rst_data", tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_sent", sent_count, 0);
    check("rst_tmo", timeout_count, 0);
    rst_in = 1'b1;

    // first periodic packet, then a 50-cycle ready stall with moving inputs
    push_exp();
    await_pkt("first", 18);
    for (int i = 0; i < 50; i++) begin
      player_x  = 11'($urandom);
      player_y  = 11'($urandom);
      direction = 9'($urandom_range(0, 359));
      step(1);
      check("stall_valid", tx_valid, 1);
      check("stall_data", tx_data, exp_q[0]);
    end
    player_x = 11'h0aa; player_y = 11'h555; direction = 9'd359;
    run_pkt("p0", 4);
    check("sent_1", sent_count, 1);
    push_exp();
    await_pkt("p1", pred(i_edge, last_c, NONE));
    run_pkt("p1", 0);
    push_exp();
    await_pkt("p2", pred(i_edge, last_c, NONE));

    // 40-cycle stall spanning two ticks -> exactly one follow-up
    step(40);
    check("stall40_valid", tx_valid, 1);
    run_pkt("p2", 0);
    push_exp();
    await_pkt("p3", pred(i_edge, last_c, NONE));
    run_pkt("p3", 0);
    push_exp();
    await_pkt("p4", pred(i_edge, last_c, NONE));
    run_pkt("p4", 0);

    // reset burst: three flagged packets back-to-back, then an unflagged one
    step(2);
    reset_req = 1'b1;
    step(1);
    reset_req = 1'b0;
    m_rcnt = 3;
    push_exp();
    await_pkt("rst0", pred(i_edge, last_c, cyc));
    for (int k = 0; k < 3; k++) begin
      run_pkt("rstpkt", 4);
      push_exp();
      if (k < 2) await_pkt("rstnext", pred(i_edge, last_c, i_edge));
      else await_pkt("rstafter", pred(i_edge, last_c, NONE));
    end
    check("sent_burst", sent_count, 16'(m_sent));

    // game_stat 0->1 in IDLE, then 1->2 while waiting for done
    run_pkt("p8", 2);
    step(2);
    game_stat = 3'd1;
    push_exp();
    await_pkt("g1", pred(i_edge, last_c, cyc + 1));
    accept("g1");
    step(1);
    game_stat = 3'd2;
    step(2);
    tx_done = 1'b1;
    step(1);
    tx_done = 1'b0;
    m_sent++;
    i_edge = cyc + 2;
    last_c = v_edge - 1;
    push_exp();
    await_pkt("g2", pred(i_edge, last_c, i_edge));
    run_pkt("g2", 1);
    push_exp();
    await_pkt("g2_once", pred(i_edge, last_c, NONE));

    // timeout with no tx_done, then saturation
    accept("to0");
    step(31);
    check("tmo_before", timeout_count, 0);
    step(1);
    check("tmo_one", timeout_count, 1);
    check("tmo_sent", sent_count, 16'(m_sent));
    step(2);
    check("tmo_idle", busy, 0);
    i_edge = cyc;
    last_c = v_edge - 1;
    for (int k = 0; k < 300; k++) begin
      push_exp();
      await_pkt("tmo_loop", pred(i_edge, last_c, NONE));
      accept("tmo_loop");
      step(34);
      i_edge = cyc;
      last_c = v_edge - 1;
    end
    check("tmo_sat", timeout_count, 255);

    // asynchronous reset during an offered packet
    push_exp();
    await_pkt("pre_rst", pred(i_edge, last_c, NONE));
    void'(exp_q.pop_front());
    @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    check("arst_valid", tx_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_sent", sent_count, 0);
    check("arst_tmo", timeout_count, 0);
    check("arst_data", tx_data, 0);
    game_stat = 3'd0;
    m_seq = 3'd0; m_rcnt = 0; m_sent = 0;
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    push_exp();
    await_pkt("post_rst", 18);
    run_pkt("post_rst", 2);
    check("post_rst_sent", sent_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
